// File: rtl/encoder_pkg.sv
// Shared definitions for the 8-to-3 priority encoder.
//   IN_W / IDX_W / CNT_W : request vector, index and popcount widths
//   state_e              : controller states
//   popcount8            : number of set bits in a request vector
package encoder_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] popcount8(input logic [IN_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < IN_W; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/priority_encoder_8x3_ffs8.sv
// ffs8: combinational 8-bit find-first-set.
//   vec       : input vector
//   lsb_first : 1 = report lowest set bit, 0 = highest set bit
//   idx       : index of the selected bit (0 when vec is zero)
//   found     : vec has at least one set bit
module ffs8
  import encoder_pkg::*;
(
  input  logic [IN_W-1:0]  vec,
  input  logic             lsb_first,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = |vec;
    // The last match in scan order wins, so scan away from the preferred end.
    if (lsb_first) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_8x3.sv
// priority_encoder_8x3: accepts a multi-hot request vector and streams the
// index of every set bit, one per handshake, in priority order.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request vector handshake (in_ready registered)
//   in                  : 8-bit multi-hot request vector
//   out_valid/out_ready : index stream handshake
//   out, out_last       : selected index, final beat of the captured vector
//   cnt                 : popcount of the last accepted vector
//   zero_err            : one-cycle pulse on acceptance of an all-zero vector
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// EMIT  | streaming indices of the pending mask
module priority_encoder_8x3
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out,
  output logic             out_last,
  output logic [CNT_W-1:0] cnt,
  output logic             zero_err
);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]  ffs_idx;
  logic              ffs_found;
  logic              single_d;
  logic              accept;
  logic              fire;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (accept && (in != '0)) begin
          pending_d = in;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (fire) begin
          pending_d = pending_q & ~(IN_W'(1) << out);
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The encoder looks at the next pending mask so the registered outputs
  // already carry the following index on the cycle after each handshake,
  // and simply re-register the same values while stalled.
  ffs8 u_ffs8 (
    .vec       (pending_d),
    .lsb_first (LSB_FIRST),
    .idx       (ffs_idx),
    .found     (ffs_found)
  );

  assign single_d = (pending_d != '0) && ((pending_d & (pending_d - IN_W'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_last  <= 1'b0;
      cnt       <= '0;
      zero_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= ffs_found;
      out       <= ffs_idx;
      out_last  <= single_d;
      zero_err  <= accept && (in == '0);
      if (accept) cnt <= popcount8(in);
    end
  end

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus; a
// per-instance queue of expected {last, index} beats is filled when a vector
// is driven and drained by a negedge monitor on every output handshake.
module tb_priority_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_vec = 8'h00;

  logic [1:0] rdy, ov, ol, zerr;
  logic [2:0] o [2];
  logic [3:0] c [2];

  int errors = 0;
  int checks = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [1:0] stall_prev = 2'b00;
  logic [1:0] last_prev = 2'b00;
  logic [2:0] prev_o [2];
  logic [1:0] prev_l = 2'b00;

  always #5 clk = ~clk;

  priority_encoder_8x3 #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in(in_vec), .out_valid(ov[0]), .out_ready(out_ready), .out(o[0]),
    .out_last(ol[0]), .cnt(c[0]), .zero_err(zerr[0])
  );

  priority_encoder_8x3 #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in(in_vec), .out_valid(ov[1]), .out_ready(out_ready), .out(o[1]),
    .out_last(ol[1]), .cnt(c[1]), .zero_err(zerr[1])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [3:0] qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (last_prev[k]) begin
          chk($sformatf("ready_after_last%0d", k), {7'd0, rdy[k]}, 8'd1);
          chk($sformatf("valid_after_last%0d", k), {7'd0, ov[k]}, 8'd0);
          last_prev[k] = 1'b0;
        end
        if (stall_prev[k]) begin
          chk($sformatf("stall_valid%0d", k), {7'd0, ov[k]}, 8'd1);
          chk($sformatf("stall_out%0d", k), {4'd0, ol[k], o[k]}, {4'd0, prev_l[k], prev_o[k]});
        end
        stall_prev[k] = ov[k] && !out_ready;
        prev_o[k] = o[k];
        prev_l[k] = ol[k];
        if (ov[k] && out_ready) begin
          if (qsize(k) == 0) begin
            chk($sformatf("extra_beat%0d", k), {4'd0, ol[k], o[k]}, 8'hEE);
          end else begin
            chk($sformatf("beat%0d", k), {4'd0, ol[k], o[k]}, {4'd0, qpop(k)});
            last_prev[k] = ol[k];
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] v);
    logic ok;
    int pop, n;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy == 2'b11) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("in_ready_wait", {7'd0, ok}, 8'd1);
    pop = 0;
    for (int i = 0; i < 8; i++) if (v[i]) pop++;
    n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) begin n++; q0.push_back({n == pop, 3'(i)}); end
    n = 0;
    for (int i = 7; i >= 0; i--) if (v[i]) begin n++; q1.push_back({n == pop, 3'(i)}); end
    in_valid = 1'b1;
    in_vec = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec = 8'($urandom);
    chk("cnt_lsb", {4'd0, c[0]}, 8'(pop));
    chk("cnt_msb", {4'd0, c[1]}, 8'(pop));
  endtask

  task automatic drain(input bit alt);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && ov == 2'b00) begin done = 1'b1; break; end
      @(posedge clk); #1;
      if (alt) out_ready = ~out_ready;
    end
    chk("drain_done", {7'd0, done}, 8'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_ready", {6'd0, rdy}, 8'd0);
    chk("rst_valid", {6'd0, ov}, 8'd0);
    chk("rst_out", {2'd0, o[1], o[0]}, 8'd0);
    chk("rst_cnt", {c[1], c[0]}, 8'd0);
    #9 rst_n = 1'b1;
    #1 chk("ready_before_edge", {6'd0, rdy}, 8'd0);
    @(posedge clk); #1;
    chk("ready_first_edge", {6'd0, rdy}, 8'h03);

    send(8'h04);  drain(1'b0);
    send(8'hA5);  drain(1'b0);
    send(8'h81);  drain(1'b0);
    send(8'hFF);  drain(1'b1);

    send(8'h00);
    chk("zero_err_pulse", {6'd0, zerr}, 8'h03);
    chk("zero_ready", {6'd0, rdy}, 8'h03);
    chk("zero_valid", {6'd0, ov}, 8'h00);
    @(posedge clk); #1;
    chk("zero_err_clear", {6'd0, zerr}, 8'h00);
    drain(1'b0);

    out_ready = 1'b1;
    send(8'hF0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", {6'd0, ov}, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {6'd0, ov}, 8'h00);
    chk("async_out", {1'b0, ol[1], ol[0], 2'd0, o[1]}, 8'h00);
    chk("async_out_lsb", {5'd0, o[0]}, 8'h00);
    chk("async_ready", {6'd0, rdy}, 8'h00);
    chk("async_cnt", {c[1], c[0]}, 8'h00);
    q0.delete(); q1.delete();
    stall_prev = 2'b00; last_prev = 2'b00;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("rel_ready_before_edge", {6'd0, rdy}, 8'h00);
    @(posedge clk); #1;
    chk("rel_ready_first_edge", {6'd0, rdy}, 8'h03);
    repeat (5) @(posedge clk);
    #1 chk("no_beats_after_rst", {6'd0, ov}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
